// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, counter width and lane helpers for the data-memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] BE_FULL = 4'b1111;

  // Expand a 4-bit lane enable into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: core-to-data-memory request/response bundle.
// The master side is the core; the slave side is dmem_ctrl.
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  rdata_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output rdata_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-lane synchronous write and a registered, maskable read port.
// The contents are never cleared; only the read register resets.
module dmem_array #(
  parameter int DEPTH_WORDS = 128,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [3:0]    lane_we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [31:0]   rd_mask,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) begin
          mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Read data holds between loads; a faulting access clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx] & rd_mask;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory stage with wait-state down-counter, fault check and PC stall.
// Define DMEM_BYTE_EN for byte-lane stores/loads (be==0 faults, alignment ignored).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no access in flight; stall follows req_i, request captured
//   ST_WAIT | wait states counting down; stall held high
//   ST_RESP | one-cycle ack/err; array access done on the entering edge
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk_i,
  input logic   rst_i,
  dmem_if.slave bus
);

  localparam int               AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  dmem_state_e      state_q;
  dmem_state_e      state_n;
  logic [CNT_W-1:0] cnt_q;

  logic             we_q;
  logic             fault_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             live_fault;
  logic [3:0]       live_be;
  logic [AW-1:0]    live_idx;

  logic             cur_we;
  logic             cur_fault;
  logic [AW-1:0]    cur_idx;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic [31:0]      cur_mask;

  logic             capture;
  logic             go_resp;
  logic             arr_wr;
  logic             arr_rd;
  logic             arr_clr;

  assign live_idx = bus.addr_i[AW+1:2];

`ifdef DMEM_BYTE_EN
  assign live_fault = (bus.addr_i >= ADDR_LIMIT) || (bus.be_i == 4'b0000);
  assign live_be    = bus.be_i;
`else
  logic unused_be;
  assign unused_be  = ^bus.be_i;
  assign live_fault = (bus.addr_i >= ADDR_LIMIT) || (bus.addr_i[1:0] != 2'b00);
  assign live_be    = BE_FULL;
`endif

  assign capture = (state_q == ST_IDLE) && bus.req_i;

  // With zero wait states the array is accessed on the capture edge, so the
  // access operands come straight from the bus while idle.
  always_comb begin
    cur_we    = we_q;
    cur_fault = fault_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state_q == ST_IDLE) begin
      cur_we    = bus.we_i;
      cur_fault = live_fault;
      cur_idx   = live_idx;
      cur_wdata = bus.wdata_i;
      cur_be    = live_be;
    end
  end

  assign cur_mask = lane_mask(cur_be);
  assign go_resp  = rst_i && (state_n == ST_RESP);
  assign arr_wr   = go_resp && cur_we && !cur_fault;
  assign arr_rd   = go_resp && !cur_we && !cur_fault;
  assign arr_clr  = go_resp && cur_fault;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.req_i) state_n = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == CNT_ONE) state_n = ST_RESP;
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ack_o   = 1'b0;
    bus.err_o   = 1'b0;
    bus.stall_o = 1'b0;
    unique case (state_q)
      ST_IDLE: bus.stall_o = bus.req_i;
      ST_WAIT: bus.stall_o = 1'b1;
      ST_RESP: begin
        bus.ack_o = 1'b1;
        bus.err_o = fault_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= BE_FULL;
    end else if (capture) begin
      cnt_q   <= CNT_LOAD;
      we_q    <= bus.we_i;
      fault_q <= live_fault;
      idx_q   <= live_idx;
      wdata_q <= bus.wdata_i;
      be_q    <= live_be;
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (arr_wr),
    .rd_en   (arr_rd),
    .rd_clr  (arr_clr),
    .lane_we (cur_be),
    .idx     (cur_idx),
    .wdata   (cur_wdata),
    .rd_mask (cur_mask),
    .rdata   (bus.rdata_o)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: two instances (0 and 2 wait states) driven with directed and random
// accesses, checked against an array-based reference model.
module tb_dmem_ctrl;

  localparam int DEPTH  = 128;
  localparam int W_FAST = 0;
  localparam int W_SLOW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  t_req;
  logic [1:0]  t_we;
  logic [1:0]  t_rst;
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [3:0]  t_be    [2];

  logic [1:0]  o_ack;
  logic [1:0]  o_err;
  logic [1:0]  o_stall;
  logic [31:0] o_rdata [2];

  dmem_if bus_f ();
  dmem_if bus_s ();

  assign bus_f.req_i   = t_req[0];
  assign bus_f.we_i    = t_we[0];
  assign bus_f.addr_i  = t_addr[0];
  assign bus_f.wdata_i = t_wdata[0];
  assign bus_f.be_i    = t_be[0];
  assign bus_s.req_i   = t_req[1];
  assign bus_s.we_i    = t_we[1];
  assign bus_s.addr_i  = t_addr[1];
  assign bus_s.wdata_i = t_wdata[1];
  assign bus_s.be_i    = t_be[1];

  assign o_ack   = {bus_s.ack_o, bus_f.ack_o};
  assign o_err   = {bus_s.err_o, bus_f.err_o};
  assign o_stall = {bus_s.stall_o, bus_f.stall_o};
  assign o_rdata[0] = bus_f.rdata_o;
  assign o_rdata[1] = bus_s.rdata_o;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_FAST)) u_dut_fast (
    .clk_i (clk),
    .rst_i (t_rst[0]),
    .bus   (bus_f)
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_SLOW)) u_dut_slow (
    .clk_i (clk),
    .rst_i (t_rst[1]),
    .bus   (bus_s)
  );

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] rd_m  [2];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] be);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
`ifdef DMEM_BYTE_EN
    for (int k = 0; k < 4; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
`endif
    return m;
  endfunction

  function automatic logic fault_of(input logic [31:0] addr, input logic [3:0] be);
    logic f;
    f = (addr >= 32'(DEPTH * 4));
`ifdef DMEM_BYTE_EN
    f = f || (be == 4'b0000);
`else
    f = f || ((addr % 4) != 0);
`endif
    return f;
  endfunction

  // One complete access on instance s, starting from an idle controller.
  task automatic access(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int          w;
    int          lat;
    int          nstall;
    int          idx;
    logic        flt;
    logic        st_at_ack;
    logic        err_at_ack;
    logic [31:0] rd_at_ack;
    logic [31:0] m;
    w          = (s == 1) ? W_SLOW : W_FAST;
    lat        = -1;
    nstall     = 0;
    st_at_ack  = 1'b0;
    err_at_ack = 1'b0;
    rd_at_ack  = '0;
    flt        = fault_of(addr, be);
    m          = mask_of(be);
    idx        = int'(addr >> 2);
    if (flt) begin
      rd_m[s] = '0;
    end else if (we) begin
      mem_m[s][idx] = (mem_m[s][idx] & ~m) | (wdata & m);
    end else begin
      rd_m[s] = mem_m[s][idx] & m;
    end

    @(posedge clk); #1;
    t_req[s] = 1'b1; t_we[s] = we; t_addr[s] = addr; t_wdata[s] = wdata; t_be[s] = be;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (o_ack[s]) begin
        lat        = c;
        st_at_ack  = o_stall[s];
        err_at_ack = o_err[s];
        rd_at_ack  = o_rdata[s];
      end else if (o_stall[s]) begin
        nstall++;
      end
    end
    t_req[s] = 1'b0;
    check_val("ack_latency", lat, w + 1);
    check_val("stall_cycles", nstall, w + 1);
    check_val("stall_in_resp", 32'(st_at_ack), 32'd0);
    check_val("err", 32'(err_at_ack), 32'(flt));
    check_val("rdata", rd_at_ack, rd_m[s]);
  endtask

  task automatic back_to_back();
    @(posedge clk); #1;
    t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 32'h40; t_be[0] = 4'hF;
    @(negedge clk);
    check_val("b2b_stall0", 32'(o_stall[0]), 32'd1);
    check_val("b2b_ack0", 32'(o_ack[0]), 32'd0);
    @(negedge clk);
    check_val("b2b_ack1", 32'(o_ack[0]), 32'd1);
    check_val("b2b_stall1", 32'(o_stall[0]), 32'd0);
    check_val("b2b_rdata1", o_rdata[0], mem_m[0][16]);
    t_addr[0] = 32'h7C;
    @(negedge clk);
    check_val("b2b_stall2", 32'(o_stall[0]), 32'd1);
    check_val("b2b_ack2", 32'(o_ack[0]), 32'd0);
    @(negedge clk);
    check_val("b2b_ack3", 32'(o_ack[0]), 32'd1);
    check_val("b2b_rdata3", o_rdata[0], mem_m[0][31]);
    t_req[0] = 1'b0;
    rd_m[0] = mem_m[0][31];
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    t_req[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 32'h20;
    t_wdata[1] = 32'h1234_5678; t_be[1] = 4'hF;
    @(negedge clk);
    check_val("rw_stall_req", 32'(o_stall[1]), 32'd1);
    @(posedge clk); #1;
    t_rst[1] = 1'b0;
    t_req[1] = 1'b0;
    @(negedge clk);
    check_val("rw_stall_wait", 32'(o_stall[1]), 32'd1);
    @(negedge clk);
    check_val("rw_ack", 32'(o_ack[1]), 32'd0);
    check_val("rw_err", 32'(o_err[1]), 32'd0);
    check_val("rw_stall", 32'(o_stall[1]), 32'd0);
    check_val("rw_rdata", o_rdata[1], 32'd0);
    rd_m[1] = '0;
    t_rst[1] = 1'b1;
    access(1, 1'b0, 32'h20, 32'd0, 4'hF);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return ($urandom_range(DEPTH * 4, DEPTH * 16)) & 32'hFFFF_FFFC;
    if (r == 1) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  initial begin
    t_req = '0; t_we = '0; t_rst = '0;
    for (int s = 0; s < 2; s++) begin
      t_addr[s] = '0; t_wdata[s] = '0; t_be[s] = 4'hF; rd_m[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_val("rst_ack", 32'(o_ack[s]), 32'd0);
      check_val("rst_err", 32'(o_err[s]), 32'd0);
      check_val("rst_stall", 32'(o_stall[s]), 32'd0);
      check_val("rst_rdata", o_rdata[s], 32'd0);
    end
    t_rst = 2'b11;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) access(s, 1'b1, 32'(i * 4), $urandom, 4'hF);
    end

    access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    access(1, 1'b0, 32'h10, 32'd0, 4'hF);
    access(1, 1'b0, 32'h11, 32'd0, 4'hF);
    access(1, 1'b0, 32'h10, 32'd0, 4'hF);
    access(1, 1'b1, 32'h200, 32'h55AA_55AA, 4'hF);
    access(1, 1'b0, 32'h0, 32'd0, 4'hF);

    access(1, 1'b1, 32'h0, 32'd0, 4'hF);
    access(1, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101);
    access(1, 1'b0, 32'h0, 32'd0, 4'hF);
    access(1, 1'b0, 32'h0, 32'd0, 4'b0000);

    access(0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
    access(0, 1'b0, 32'h10, 32'd0, 4'hF);
    back_to_back();
    reset_in_wait();

    for (int n = 0; n < 300; n++) begin
      int          s;
      logic [3:0]  be;
      s  = int'($urandom_range(0, 1));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      access(s, 1'($urandom_range(0, 1)), rand_addr(), $urandom, be);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
